// File: rtl/turbo_sched_if.sv
// turbo_sched_if: CPU/config inputs and applied-turbo outputs of the turbo scheduler
interface turbo_sched_if;
   logic        ck35;
   logic [2:0]  cfg_turbo;
   logic        autoturbo_en;
   logic        magic_map;
   logic        div_paged;
   logic        basic48_paged;
   logic        m1;
   logic        ioreq;
   logic [15:0] a;
   logic [2:0]  turbo;
   logic [1:0]  turbo_src;
   logic        switch_stb;
   modport master (
      output ck35, cfg_turbo, autoturbo_en, magic_map, div_paged, basic48_paged, m1, ioreq, a,
      input  turbo, turbo_src, switch_stb
   );
   modport slave (
      input  ck35, cfg_turbo, autoturbo_en, magic_map, div_paged, basic48_paged, m1, ioreq, a,
      output turbo, turbo_src, switch_stb
   );
endinterface

// File: rtl/turbo_sched.sv
// turbo_sched: arbitrates turbo requesters and applies the winner at opcode-fetch boundaries with a minimum dwell
module turbo_sched #(
   parameter int DWELL_TICKS = 16,
   parameter int FE_HOLD_W   = 12
) (
   input logic          clk28,
   input logic          rst,
   turbo_sched_if.slave bus
);
   localparam int DW = $clog2(DWELL_TICKS + 1);
   typedef enum logic [1:0] {SRC_CFG, SRC_DIV, SRC_FE, SRC_RAMCLR} src_e;
   logic [FE_HOLD_W-1:0] fe_cnt_q, fe_cnt_d;
   logic [DW-1:0]        dwell_q, dwell_d;
   logic [2:0]           turbo_q, turbo_d, cfg_san, req;
   src_e                 src_q, src_d, src;
   logic                 ramclr_q, ramclr_d, m1_q, stb_q, stb_d;
   logic                 ramclr_hit, fe_access, fe_hold, sw_pt, urgent, upd;
   logic                 unused_a;
   assign unused_a   = ^bus.a[5:1];
   assign ramclr_hit = bus.a[15:6] == 10'b0001000111;
   assign fe_access  = bus.ioreq && !bus.a[0];
   assign fe_hold    = fe_cnt_q != '0;
   assign cfg_san    = bus.cfg_turbo > 3'd4 ? 3'd0 : bus.cfg_turbo;
   assign sw_pt      = bus.m1 && !m1_q;
   // requester arbitration from registered hold state, first match wins
   always_comb begin
      req = cfg_san;
      src = SRC_CFG;
      if (bus.autoturbo_en) begin
         if (bus.div_paged && !bus.magic_map) begin
            req = 3'd4;
            src = SRC_DIV;
         end else if (fe_hold) begin
            req = 3'd0;
            src = SRC_FE;
         end else if (ramclr_q) begin
            req = 3'd4;
            src = SRC_RAMCLR;
         end
      end
   end
   // apply decision and next-state of hold-off, RAM-clear and dwell trackers
   always_comb begin
      urgent   = req == 3'd0 && src == SRC_FE;
      upd      = sw_pt && (req != turbo_q || src != src_q) && (dwell_q == '0 || urgent);
      stb_d    = upd && req != turbo_q;
      turbo_d  = upd ? req : turbo_q;
      src_d    = upd ? src : src_q;
      dwell_d  = upd ? DW'(DWELL_TICKS) : (bus.ck35 && dwell_q != '0) ? dwell_q - 1'b1 : dwell_q;
      fe_cnt_d = fe_access ? FE_HOLD_W'(1) : (fe_hold && bus.ck35) ? fe_cnt_q + 1'b1 : fe_cnt_q;
      ramclr_d = (bus.basic48_paged && bus.m1 && ramclr_hit) ? 1'b1 :
                 (!bus.basic48_paged || (bus.m1 && !ramclr_hit)) ? 1'b0 : ramclr_q;
   end
   // state registers; m1_q resets high so an m1 held across reset is not a switch point
   always_ff @(posedge clk28) begin
      if (rst) begin
         turbo_q  <= '0;
         src_q    <= SRC_CFG;
         stb_q    <= 1'b0;
         fe_cnt_q <= '0;
         ramclr_q <= 1'b0;
         dwell_q  <= '0;
         m1_q     <= 1'b1;
      end else begin
         turbo_q  <= turbo_d;
         src_q    <= src_d;
         stb_q    <= stb_d;
         fe_cnt_q <= fe_cnt_d;
         ramclr_q <= ramclr_d;
         dwell_q  <= dwell_d;
         m1_q     <= bus.m1;
      end
   end
   assign bus.turbo      = turbo_q;
   assign bus.turbo_src  = src_q;
   assign bus.switch_stb = stb_q;
endmodule

// File: tb/tb_turbo_sched.sv
// tb_turbo_sched: directed and randomized checks of turbo_sched against a tick-level reference model
module tb_turbo_sched;
   localparam int DWELL  = 16;
   localparam int FE_W   = 12;
   localparam int FE_MAX = (1 << FE_W) - 1;
   logic clk28 = 1'b0;
   logic rst   = 1'b1;
   turbo_sched_if bus();
   turbo_sched #(.DWELL_TICKS(DWELL), .FE_HOLD_W(FE_W)) dut (.clk28(clk28), .rst(rst), .bus(bus.slave));
   always #5 clk28 = ~clk28;
   int n_cmp = 0, n_bad = 0, phase = 0;
   bit rand_ck = 1'b0;
   int m_turbo, m_src, fe_ticks, dw_ticks;
   bit m_stb, m_pm1, fe_act, m_ramclr;
   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_turbo = 0; m_src = 0; m_stb = 0; m_pm1 = 1; fe_act = 0; fe_ticks = 0; m_ramclr = 0;
      dw_ticks = DWELL;
   endtask
   task automatic cyc();
      bit ck, io, m1v, aut, div, mag, b48, r, sw, upd, hit;
      logic [15:0] av;
      int cfg, san, req, src;
      ck = rand_ck ? ($urandom_range(0, 2) == 0) : (phase % 4 == 0);
      phase++;
      bus.ck35 = ck;
      io = bus.ioreq; m1v = bus.m1; aut = bus.autoturbo_en; div = bus.div_paged;
      mag = bus.magic_map; b48 = bus.basic48_paged; av = bus.a; cfg = int'(bus.cfg_turbo); r = rst;
      @(posedge clk28);
      if (r) model_reset();
      else begin
         san = cfg > 4 ? 0 : cfg;
         if (!aut) begin req = san; src = 0; end
         else if (div && !mag) begin req = 4; src = 1; end
         else if (fe_act) begin req = 0; src = 2; end
         else if (m_ramclr) begin req = 4; src = 3; end
         else begin req = san; src = 0; end
         sw  = m1v && !m_pm1;
         upd = sw && (req != m_turbo || src != m_src) && (dw_ticks >= DWELL || (req == 0 && src == 2));
         m_stb = upd && req != m_turbo;
         if (upd) begin m_turbo = req; m_src = src; dw_ticks = 0; end
         else if (ck && dw_ticks < DWELL) dw_ticks++;
         if (io && !av[0]) begin fe_act = 1; fe_ticks = 0; end
         else if (fe_act && ck) begin
            fe_ticks++;
            if (fe_ticks == FE_MAX) fe_act = 0;
         end
         hit = (av >> 6) == 16'h0047;
         if (b48 && m1v && hit) m_ramclr = 1;
         else if (!b48 || (m1v && !hit)) m_ramclr = 0;
         m_pm1 = m1v;
      end
      #1;
      check("turbo", int'(bus.turbo), m_turbo);
      check("turbo_src", int'(bus.turbo_src), m_src);
      check("switch_stb", int'(bus.switch_stb), int'(m_stb));
   endtask
   task automatic idle(input int n);
      repeat (n) cyc();
   endtask
   task automatic fetch(input logic [15:0] addr);
      bus.a = addr; bus.m1 = 1'b1;
      repeat (3) cyc();
      bus.m1 = 1'b0;
      repeat (3) cyc();
   endtask
   task automatic fe_out();
      bus.a = 16'h00FE; bus.ioreq = 1'b1;
      cyc();
      bus.ioreq = 1'b0;
   endtask
   task automatic expect_out(input string tag, input int t, input int s);
      check({tag, ".turbo"}, int'(bus.turbo), t);
      check({tag, ".src"}, int'(bus.turbo_src), s);
   endtask
   initial begin
      model_reset();
      bus.ck35 = 0; bus.cfg_turbo = 0; bus.autoturbo_en = 0; bus.magic_map = 0; bus.div_paged = 0;
      bus.basic48_paged = 0; bus.m1 = 0; bus.ioreq = 0; bus.a = 0;
      idle(3);
      rst = 1'b0;
      expect_out("reset", 0, 0);
      check("reset.stb", int'(bus.switch_stb), 0);
      idle(4);
      bus.cfg_turbo = 3'd3;
      idle(10);
      expect_out("cfg_no_m1", 0, 0);
      fetch(16'h0000);
      expect_out("cfg3", 3, 0);
      idle(80);
      bus.autoturbo_en = 1; bus.cfg_turbo = 0; bus.div_paged = 1;
      fetch(16'h0000);
      expect_out("div", 4, 1);
      bus.magic_map = 1;
      fetch(16'h0004);
      expect_out("div_dwell", 4, 1);
      idle(80);
      fetch(16'h0008);
      expect_out("magic_cfg", 0, 0);
      bus.magic_map = 0;
      idle(80);
      fetch(16'h000C);
      expect_out("div2", 4, 1);
      bus.div_paged = 0;
      fe_out();
      fetch(16'h0010);
      expect_out("fe_urgent", 0, 2);
      bus.cfg_turbo = 3'd2;
      idle(16000);
      fetch(16'h0014);
      expect_out("fe_hold4000", 0, 2);
      fe_out();
      idle(16000);
      fetch(16'h0018);
      expect_out("fe_restart", 0, 2);
      repeat (120) fetch(16'h0100);
      expect_out("fe_expired", 2, 0);
      bus.basic48_paged = 1;
      fetch(16'h11C0);
      idle(80);
      fetch(16'h11FC);
      expect_out("ramclr", 4, 3);
      fetch(16'h1200);
      expect_out("ramclr_dwell", 4, 3);
      idle(80);
      fetch(16'h1204);
      expect_out("ramclr_end", 2, 0);
      bus.basic48_paged = 0; bus.autoturbo_en = 0; bus.cfg_turbo = 3'd6;
      idle(80);
      fetch(16'h0020);
      expect_out("cfg6", 0, 0);
      bus.cfg_turbo = 3'd3;
      idle(80);
      fetch(16'h0024);
      expect_out("cfg3b", 3, 0);
      rst = 1'b1;
      cyc();
      expect_out("rst_mid", 0, 0);
      check("rst_mid.stb", int'(bus.switch_stb), 0);
      rst = 1'b0;
      rand_ck = 1'b1;
      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(0, 49) == 0) bus.cfg_turbo = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 199) == 0) bus.autoturbo_en = ~bus.autoturbo_en;
         if ($urandom_range(0, 199) == 0) bus.magic_map = ~bus.magic_map;
         if ($urandom_range(0, 149) == 0) bus.div_paged = ~bus.div_paged;
         if ($urandom_range(0, 149) == 0) bus.basic48_paged = ~bus.basic48_paged;
         if ($urandom_range(0, 3) == 0) bus.m1 = ~bus.m1;
         case ($urandom_range(0, 3))
            0, 1:    bus.a = 16'h11C0 + 16'($urandom_range(0, 63));
            2:       bus.a = 16'h1200;
            default: bus.a = 16'($urandom);
         endcase
         if ($urandom_range(0, 2999) == 0) begin
            bus.ioreq = 1'b1; bus.a[0] = 1'b0;
         end else begin
            bus.ioreq = $urandom_range(0, 7) == 0;
            if (bus.ioreq) bus.a[0] = 1'b1;
         end
         rst = $urandom_range(0, 4999) == 0;
         cyc();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
